// File: rtl/brainwars_game_sched.sv
// Brain Wars round scheduler: countdown/play/result sequencing over up to three engines.
// Define BW_SCHED_SHUFFLE_EN to start each match at an LFSR-chosen engine.
module brainwars_game_sched #(
   parameter int NUM_GAMES     = 3,
   parameter int COUNTDOWN_SEC = 3,
   parameter int ROUND_SEC     = 30,
   parameter int RESULT_SEC    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_1hz,
   input  logic         start,
   input  logic [2:0]   game_done,
   input  logic [2:0]   game_point,
   input  logic [383:0] game_data,
   output logic [2:0]   game_en,
   output logic [127:0] data_output,
   output logic [7:0]   score,
   output logic [1:0]   round_idx,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_COUNT  = 3'd1,
      S_PLAY   = 3'd2,
      S_RESULT = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   localparam logic [5:0] L_CD   = 6'(COUNTDOWN_SEC);
   localparam logic [5:0] L_RS   = 6'(ROUND_SEC);
   localparam logic [5:0] L_RES  = 6'(RESULT_SEC);
   localparam logic [1:0] L_LAST = 2'(NUM_GAMES - 1);
   localparam logic [2:0] L_NG   = 3'(NUM_GAMES);

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [1:0]  r_round;
   logic [7:0]  r_score;
   logic [1:0]  r_g0;

   state_t      w_state_nxt;
   logic [5:0]  w_cnt_nxt;
   logic [1:0]  w_round_nxt;
   logic [7:0]  w_score_nxt;
   logic [1:0]  w_g0_nxt;
   logic [1:0]  w_g0_new;
   logic [2:0]  w_sum;
   logic [1:0]  w_act;
   logic        w_last_tick;

`ifdef BW_SCHED_SHUFFLE_EN
   logic [3:0]  r_lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= 4'b1001;
      end else begin
         r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      end
   end

   assign w_g0_new = 2'(r_lfsr % 4'(NUM_GAMES));
`else
   assign w_g0_new = 2'd0;
`endif

   // g0 and round_idx are both below NUM_GAMES, so one subtraction is a full mod
   assign w_sum       = {1'b0, r_g0} + {1'b0, r_round};
   assign w_act       = (w_sum >= L_NG) ? 2'(w_sum - L_NG) : w_sum[1:0];
   assign w_last_tick = tick_1hz && (r_cnt == 6'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_round <= 2'd0;
         r_score <= 8'd0;
         r_g0    <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_round <= w_round_nxt;
         r_score <= w_score_nxt;
         r_g0    <= w_g0_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_round_nxt = r_round;
      w_score_nxt = r_score;
      w_g0_nxt    = r_g0;
      unique case (r_state)
         S_IDLE, S_FINISH: begin
            if (start) begin
               w_state_nxt = S_COUNT;
               w_cnt_nxt   = L_CD;
               w_round_nxt = 2'd0;
               w_score_nxt = 8'd0;
               w_g0_nxt    = w_g0_new;
            end
         end
         S_COUNT: begin
            if (w_last_tick) begin
               w_state_nxt = S_PLAY;
               w_cnt_nxt   = L_RS;
            end else if (tick_1hz) begin
               w_cnt_nxt = r_cnt - 6'd1;
            end
         end
         S_PLAY: begin
            if (game_point[w_act] && (r_score != 8'hFF)) begin
               w_score_nxt = r_score + 8'd1;
            end
            if (game_done[w_act] || w_last_tick) begin
               w_state_nxt = S_RESULT;
               w_cnt_nxt   = L_RES;
            end else if (tick_1hz) begin
               w_cnt_nxt = r_cnt - 6'd1;
            end
         end
         S_RESULT: begin
            if (w_last_tick) begin
               if (r_round == L_LAST) begin
                  w_state_nxt = S_FINISH;
               end else begin
                  w_state_nxt = S_COUNT;
                  w_round_nxt = r_round + 2'd1;
                  w_cnt_nxt   = L_CD;
               end
            end else if (tick_1hz) begin
               w_cnt_nxt = r_cnt - 6'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Status frame shown to the LCD whenever no engine owns the display
   always_comb begin
      if (r_state == S_PLAY) begin
         data_output = game_data[{w_act, 7'd0} +: 128];
      end else begin
         data_output = {5'b10100, r_state, 4'h0, r_cnt[3:0], r_score,
                        6'h0, r_round, 96'h0};
      end
   end

   assign game_en   = (r_state == S_PLAY) ? (3'b001 << w_act) : 3'b000;
   assign busy      = (r_state != S_IDLE);
   assign score     = r_score;
   assign round_idx = r_round;

endmodule

// File: tb/tb_brainwars_game_sched.sv
// Bench for brainwars_game_sched: directed match plus randomized matches
// checked every cycle against a phase/counter model of the game flow.
module tb_brainwars_game_sched;

   localparam int NG    = 3;
   localparam int CD    = 3;
   localparam int RS    = 30;
   localparam int RES   = 2;
   localparam int BOUND = 3000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick_1hz = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   game_done = 3'b0;
   logic [2:0]   game_point = 3'b0;
   logic [383:0] game_data = '0;
   logic [2:0]   game_en;
   logic [127:0] data_output;
   logic [7:0]   score;
   logic [1:0]   round_idx;
   logic         busy;

   int vectors = 0;
   int miscompares = 0;

   // model: phase 0 idle, 1 countdown, 2 play, 3 result, 4 finished
   int m_ph = 0;
   int m_cnt = 0;
   int m_round = 0;
   int m_score = 0;
   int m_g0 = 0;
   int m_lfsr = 9;

   brainwars_game_sched #(
      .NUM_GAMES(NG), .COUNTDOWN_SEC(CD),
      .ROUND_SEC(RS), .RESULT_SEC(RES)
   ) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start),
      .game_done(game_done), .game_point(game_point),
      .game_data(game_data), .game_en(game_en),
      .data_output(data_output), .score(score),
      .round_idx(round_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int active_game();
      return (m_g0 + m_round) % NG;
   endfunction

   always @(posedge clk) begin
      int act;
      int fb;
      if (rst) begin
         m_ph = 0; m_cnt = 0; m_round = 0;
         m_score = 0; m_g0 = 0; m_lfsr = 9;
      end else begin
         act = active_game();
         case (m_ph)
            0, 4: if (start) begin
               m_ph = 1; m_cnt = CD; m_round = 0; m_score = 0;
`ifdef BW_SCHED_SHUFFLE_EN
               m_g0 = m_lfsr % NG;
`else
               m_g0 = 0;
`endif
            end
            1: if (tick_1hz) begin
               if (m_cnt == 1) begin m_ph = 2; m_cnt = RS; end
               else m_cnt--;
            end
            2: begin
               if (game_point[act] && m_score < 255) m_score++;
               if (game_done[act] || (tick_1hz && m_cnt == 1)) begin
                  m_ph = 3; m_cnt = RES;
               end else if (tick_1hz) m_cnt--;
            end
            3: if (tick_1hz) begin
               if (m_cnt != 1) m_cnt--;
               else if (m_round == NG - 1) m_ph = 4;
               else begin m_ph = 1; m_round++; m_cnt = CD; end
            end
            default: m_ph = 0;
         endcase
         fb = ((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1;
         m_lfsr = ((m_lfsr << 1) & 15) | fb;
      end
   end

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [127:0] exp_data;
      logic [2:0]   exp_en;
      int act;
      if (!rst) begin
         act = active_game();
         exp_en = (m_ph == 2) ? 3'(1 << act) : 3'b000;
         if (m_ph == 2) exp_data = game_data[act*128 +: 128];
         else exp_data = {5'b10100, 3'(m_ph), 4'h0, 4'(m_cnt), 8'(m_score),
                          6'h0, 2'(m_round), 96'h0};
         chk("game_en", 128'(game_en), 128'(exp_en));
         chk("busy", 128'(busy), 128'(m_ph != 0));
         chk("round_idx", 128'(round_idx), 128'(m_round));
         chk("score", 128'(score), 128'(m_score));
         chk("data_output", data_output, exp_data);
      end
   end

   // one input cycle: called at posedge+1, returns at the next posedge+1
   task automatic cyc(input logic t, input logic s,
                      input logic [2:0] d, input logic [2:0] p);
      tick_1hz = t; start = s; game_done = d; game_point = p;
      for (int k = 0; k < 12; k++) game_data[k*32 +: 32] = $urandom;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 3'b0, 3'b0);
   endtask

   task automatic tk();
      cyc(1'b1, 1'b0, 3'b0, 3'b0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(10);
      chk("rst_game_en", 128'(game_en), 128'(3'b000));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_hdr", 128'(data_output[127:120]), 128'(8'hA0));
      chk("rst_score", 128'(score), 128'(8'd0));

`ifndef BW_SCHED_SHUFFLE_EN
      cyc(1'b0, 1'b1, 3'b0, 3'b0);
      tk(); idle(1); tk(); idle(1); tk();
      chk("first_play_en", 128'(game_en), 128'(3'b001));
      idle(2);
      cyc(1'b0, 1'b0, 3'b001, 3'b0);
      chk("done_en_drop", 128'(game_en), 128'(3'b000));
      tk(); tk();
      chk("round1_idx", 128'(round_idx), 128'(2'd1));
      tk(); tk(); tk();
      chk("round1_en", 128'(game_en), 128'(3'b010));
      repeat (5) cyc(1'b0, 1'b0, 3'b0, 3'b111);
      chk("five_points", 128'(score), 128'(8'd5));
      repeat (3) cyc(1'b0, 1'b0, 3'b0, 3'b101);
      chk("inactive_points", 128'(score), 128'(8'd5));
      for (int i = 0; i < 30; i++) begin
         if (i == 29) chk("pre_timeout_en", 128'(game_en), 128'(3'b010));
         tk();
         if (i < 29) idle(1);
      end
      chk("timeout_en", 128'(game_en), 128'(3'b000));
      tk(); tk(); tk(); tk(); tk();
      chk("round2_en", 128'(game_en), 128'(3'b100));
      repeat (249) cyc(1'b0, 1'b0, 3'b0, 3'b100);
      chk("score_254", 128'(score), 128'(8'd254));
      repeat (3) cyc(1'b0, 1'b0, 3'b0, 3'b100);
      chk("score_sat", 128'(score), 128'(8'd255));
      cyc(1'b0, 1'b0, 3'b100, 3'b0);
      tk(); tk();
      idle(3);
      chk("finish_busy", 128'(busy), 128'(1'b1));
      chk("finish_score_fld", 128'(data_output[111:104]), 128'(8'hFF));
      chk("finish_hdr", 128'(data_output[127:120]), 128'(8'hA4));
`endif

      cyc(1'b0, 1'b1, 3'b0, 3'b0);
      chk("restart_score", 128'(score), 128'(8'd0));
      chk("restart_state", 128'(data_output[122:120]), 128'(3'd1));
      tk(); tk(); tk();
      idle(2);
      #1 rst = 1'b1;
      #1 chk("async_rst_en", 128'(game_en), 128'(3'b000));
      chk("async_rst_busy", 128'(busy), 128'(1'b0));
      @(posedge clk); #1 rst = 1'b0;

      for (int m = 0; m < 20; m++) begin
         idle($urandom_range(0, 7));
         cyc(1'($urandom % 2), 1'b1, 3'b0, 3'b0);
         n = 0;
         while (m_ph != 4 && n < BOUND) begin
            cyc(1'($urandom % 3 == 0), 1'($urandom % 8 == 0),
                {1'($urandom % 20 == 0), 1'($urandom % 20 == 0),
                 1'($urandom % 20 == 0)},
                3'($urandom));
            n++;
         end
         vectors++;
         if (n >= BOUND) begin
            miscompares++;
            $display("FAIL match_timeout: %0d cycles, required < %0d", n, BOUND);
         end
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
